// File: rtl/ahb_slave_mem.sv
// AHB-Lite responder backed by an internal word memory.
// Decodes a single address window, services single read/write transfers with
// a configurable number of wait states, and answers illegal accesses with the
// two-cycle ERROR response.
module ahb_slave_mem #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          MEM_WORDS   = 256,
  parameter int          WAIT_STATES = 1
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic        Hsel,
  input  logic [31:0] Haddr,
  input  logic        Hwrite,
  input  logic [2:0]  Hsize,
  input  logic [1:0]  Htrans,
  input  logic        Hready,
  input  logic [31:0] Hwdata,
  output logic [31:0] Hrdata,
  output logic        Hready_out,
  output logic        Hresp
);

  localparam int         IDX_W   = $clog2(MEM_WORDS);
  localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  // First data-phase state of a legal transfer depends on whether waits exist.
  localparam state_t ST_OKAY_FIRST = (WAIT_STATES > 0) ? ST_WAIT : ST_DATA;

  state_t             state_r;
  state_t             state_nx_s;
  logic [3:0]         wait_cnt_r;
  logic [IDX_W-1:0]   idx_r;
  logic [1:0]         lane_r;
  logic [2:0]         size_r;
  logic               write_r;
  logic [31:0]        mem_r [MEM_WORDS];

  logic [31:0]        offset_s;
  logic               in_range_s;
  logic               aligned_s;
  logic               legal_s;
  logic               accept_window_s;
  logic               accept_s;
  logic [3:0]         byte_en_s;
  logic               unused_s;

  // Byte enables for a little-endian write of the given size at the given lane.
  function automatic logic [3:0] lane_enables(input logic [2:0] size, input logic [1:0] lane);
    case (size)
      3'd0:    return 4'b0001 << lane;
      3'd1:    return lane[1] ? 4'b1100 : 4'b0011;
      3'd2:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  assign unused_s = Htrans[0];

  // Address-phase decode: window check, size and alignment legality, accept.
  always_comb begin
    offset_s   = Haddr - ADDR_BASE;
    in_range_s = (offset_s < 32'(MEM_WORDS * 4));
    case (Hsize)
      3'd0:    aligned_s = 1'b1;
      3'd1:    aligned_s = (offset_s[0] == 1'b0);
      3'd2:    aligned_s = (offset_s[1:0] == 2'b00);
      default: aligned_s = 1'b0;
    endcase
    legal_s = in_range_s && (Hsize <= 3'd2) && aligned_s;
    case (state_r)
      ST_IDLE, ST_DATA, ST_ERR2: accept_window_s = 1'b1;
      default:                   accept_window_s = 1'b0;
    endcase
    accept_s  = Hsel && Hready && Htrans[1] && accept_window_s;
    byte_en_s = lane_enables(size_r, lane_r);
  end

  // State register.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic, including back-to-back accepts from DATA and ERR2.
  always_comb begin
    state_nx_s = ST_IDLE;
    case (state_r)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (accept_s) begin
          state_nx_s = legal_s ? ST_OKAY_FIRST : ST_ERR1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_r == 4'd0) begin
          state_nx_s = ST_DATA;
        end else begin
          state_nx_s = ST_WAIT;
        end
      end
      ST_ERR1: state_nx_s = ST_ERR2;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Captured transfer attributes and the saturating wait counter.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      idx_r      <= '0;
      lane_r     <= 2'b00;
      size_r     <= 3'd0;
      write_r    <= 1'b0;
      wait_cnt_r <= 4'd0;
    end else begin
      if (accept_s) begin
        idx_r   <= offset_s[IDX_W+1:2];
        lane_r  <= offset_s[1:0];
        size_r  <= Hsize;
        write_r <= Hwrite && legal_s;
      end
      if (accept_s && legal_s) begin
        wait_cnt_r <= WS_INIT;
      end else if ((state_r == ST_WAIT) && (wait_cnt_r != 4'd0)) begin
        wait_cnt_r <= wait_cnt_r - 4'd1;
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
    end
  end

  // Memory write commits on the edge closing the DATA cycle; contents are not reset.
  always_ff @(posedge Hclk) begin
    if ((state_r == ST_DATA) && write_r) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en_s[b]) begin
          mem_r[idx_r][8*b +: 8] <= Hwdata[8*b +: 8];
        end
      end
    end
  end

  // Response outputs decoded from the registered state only.
  always_comb begin
    Hready_out = 1'b1;
    Hresp      = 1'b0;
    Hrdata     = 32'h0000_0000;
    case (state_r)
      ST_WAIT: begin
        Hready_out = 1'b0;
        Hresp      = 1'b0;
      end
      ST_DATA: begin
        Hready_out = 1'b1;
        Hresp      = 1'b0;
        if (!write_r) begin
          Hrdata = mem_r[idx_r];
        end else begin
          Hrdata = 32'h0000_0000;
        end
      end
      ST_ERR1: begin
        Hready_out = 1'b0;
        Hresp      = 1'b1;
      end
      ST_ERR2: begin
        Hready_out = 1'b1;
        Hresp      = 1'b1;
      end
      default: begin
        Hready_out = 1'b1;
        Hresp      = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: three instances (3, 1 and 0 wait states) share the
// bus; each sees its own Hsel and its own Hready_out as Hready. A transaction
// level model predicts the per-cycle response trace of every instance.
module tb_ahb_slave_mem;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [33:0] IDLE_RSP = {1'b1, 1'b0, 32'h0000_0000};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  hsel = 3'b000;
  logic [31:0] haddr = 32'h0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd0;
  logic [1:0]  htrans = T_IDLE;
  logic [31:0] hwdata = 32'h0;
  logic [31:0] hrdata [3];
  logic [2:0]  hrdy;
  logic [2:0]  hresp;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ahb_slave_mem #(
      .ADDR_BASE   (32'h0000_0000),
      .MEM_WORDS   (256),
      .WAIT_STATES (g == 0 ? 3 : (g == 1 ? 1 : 0))
    ) u_dut (
      .Hclk       (clk),
      .Hreset     (rst),
      .Hsel       (hsel[g]),
      .Haddr      (haddr),
      .Hwrite     (hwrite),
      .Hsize      (hsize),
      .Htrans     (htrans),
      .Hready     (hrdy[g]),
      .Hwdata     (hwdata),
      .Hrdata     (hrdata[g]),
      .Hready_out (hrdy[g]),
      .Hresp      (hresp[g])
    );
  end

  function automatic int ws(input int k);
    return (k == 0) ? 3 : ((k == 1) ? 1 : 0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // Each queue entry is the expected {ready, resp, rdata} of one future cycle.
  logic [33:0] expq [3][$];
  logic [33:0] cur [3] = '{IDLE_RSP, IDLE_RSP, IDLE_RSP};
  logic        pw_v [3] = '{1'b0, 1'b0, 1'b0};
  logic [7:0]  pw_idx [3];
  logic [1:0]  pw_lane [3];
  logic [2:0]  pw_sz [3];
  logic [31:0] mm [3][256];

  // Model: commit pending writes, then predict the response trace of each accept.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        expq[k].delete();
        pw_v[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        logic [31:0] off;
        logic        legal;
        if (cur[k][33] && pw_v[k]) begin
          for (int b = 0; b < 4; b++) begin
            if ((b >> pw_sz[k]) == (int'(pw_lane[k]) >> pw_sz[k]))
              mm[k][pw_idx[k]][8*b +: 8] = hwdata[8*b +: 8];
          end
          pw_v[k] = 1'b0;
        end
        if (hsel[k] && htrans[1] && cur[k][33]) begin
          off   = haddr;
          legal = (off < 32'd1024) && (hsize <= 3'd2) &&
                  ((hsize == 3'd0) || (hsize == 3'd1 && off[0] == 1'b0) ||
                   (hsize == 3'd2 && off[1:0] == 2'b00));
          if (legal) begin
            for (int w = 0; w < ws(k); w++) expq[k].push_back({1'b0, 1'b0, 32'h0});
            expq[k].push_back({1'b1, 1'b0, hwrite ? 32'h0 : mm[k][off[9:2]]});
            if (hwrite) begin
              pw_v[k]    = 1'b1;
              pw_idx[k]  = off[9:2];
              pw_lane[k] = off[1:0];
              pw_sz[k]   = hsize;
            end
          end else begin
            expq[k].push_back({1'b0, 1'b1, 32'h0});
            expq[k].push_back({1'b1, 1'b1, 32'h0});
          end
        end
      end
    end
  end

  // Compare every instance against the model on every falling edge.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst || expq[k].size() == 0) cur[k] = IDLE_RSP;
      else cur[k] = expq[k].pop_front();
      check($sformatf("dut%0d_ready", k), {31'h0, hrdy[k]}, {31'h0, cur[k][33]});
      check($sformatf("dut%0d_resp", k), {31'h0, hresp[k]}, {31'h0, cur[k][32]});
      check($sformatf("dut%0d_rdata", k), hrdata[k], cur[k][31:0]);
    end
  end

  // ---------------- stimulus ----------------
  // One single transfer; called just after a rising edge with instance k idle.
  task automatic xfer(input int k, input logic [31:0] a, input logic w, input logic [2:0] s,
                      input logic [31:0] wd, output logic [31:0] rd, output logic rsp,
                      output int nlow);
    hsel[k] = 1'b1; haddr = a; hwrite = w; hsize = s; htrans = T_NONSEQ; hwdata = 32'h0;
    @(posedge clk); #1;
    // Scramble address-phase signals so the pending transfer must not depend on them.
    hsel[k] = 1'b0; htrans = T_IDLE; haddr = 32'hFFFF_FFFC; hwrite = ~w; hsize = 3'd7;
    hwdata = wd;
    nlow = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (hrdy[k]) break;
      nlow++;
    end
    if (!hrdy[k]) check("xfer_timeout", 32'h0, 32'h1);
    rd  = hrdata[k];
    rsp = hresp[k];
    @(posedge clk); #1;
    hwdata = 32'h0;
  endtask

  logic [31:0] rd;
  logic        rsp;
  int          nlow;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_ready%0d", k), {31'h0, hrdy[k]}, 32'h1);
      check($sformatf("reset_resp%0d", k), {31'h0, hresp[k]}, 32'h0);
      check($sformatf("reset_rdata%0d", k), hrdata[k], 32'h0);
    end
    @(posedge clk); #1;

    // Word write/read, one wait state.
    xfer(1, 32'h04, 1'b1, 3'd2, 32'h1234_5678, rd, rsp, nlow);
    check("ws1_write_waits", nlow, 32'd1);
    check("ws1_write_resp", {31'h0, rsp}, 32'h0);
    xfer(1, 32'h04, 1'b0, 3'd2, 32'h0, rd, rsp, nlow);
    check("ws1_read_waits", nlow, 32'd1);
    check("ws1_read_data", rd, 32'h1234_5678);

    // Byte and halfword lanes.
    xfer(1, 32'h08, 1'b1, 3'd2, 32'h0000_0000, rd, rsp, nlow);
    xfer(1, 32'h09, 1'b1, 3'd0, 32'h0000_AA00, rd, rsp, nlow);
    xfer(1, 32'h0A, 1'b1, 3'd1, 32'hBEEF_0000, rd, rsp, nlow);
    xfer(1, 32'h08, 1'b0, 3'd2, 32'h0, rd, rsp, nlow);
    check("lanes_read", rd, 32'hBEEF_AA00);

    // Illegal accesses: two-cycle ERROR, no memory write.
    xfer(1, 32'h00, 1'b1, 3'd2, 32'h55AA_55AA, rd, rsp, nlow);
    xfer(1, 32'h400, 1'b1, 3'd2, 32'hFFFF_FFFF, rd, rsp, nlow);
    check("err_range_waits", nlow, 32'd1);
    check("err_range_resp", {31'h0, rsp}, 32'h1);
    xfer(1, 32'h02, 1'b1, 3'd2, 32'h7777_7777, rd, rsp, nlow);
    check("err_align_waits", nlow, 32'd1);
    check("err_align_resp", {31'h0, rsp}, 32'h1);
    xfer(1, 32'h00, 1'b1, 3'd3, 32'h3333_3333, rd, rsp, nlow);
    check("err_size_resp", {31'h0, rsp}, 32'h1);
    xfer(1, 32'h00, 1'b0, 3'd2, 32'h0, rd, rsp, nlow);
    check("err_no_write", rd, 32'h55AA_55AA);

    // Back-to-back write then read, zero wait states.
    hsel[2] = 1'b1; haddr = 32'h20; hwrite = 1'b1; hsize = 3'd2; htrans = T_NONSEQ;
    @(posedge clk); #1;
    hwrite = 1'b0; hwdata = 32'hCAFE_F00D;
    @(negedge clk);
    check("b2b_write_ready", {31'h0, hrdy[2]}, 32'h1);
    @(posedge clk); #1;
    hsel[2] = 1'b0; htrans = T_IDLE; hwdata = 32'h0;
    @(negedge clk);
    check("b2b_read_ready", {31'h0, hrdy[2]}, 32'h1);
    check("b2b_read_data", hrdata[2], 32'hCAFE_F00D);
    @(posedge clk); #1;

    // IDLE and BUSY with Hsel high: zero-wait OKAY, no access.
    hsel[2] = 1'b1; haddr = 32'h20; hwrite = 1'b1; hsize = 3'd2; htrans = T_IDLE;
    hwdata = 32'h0BAD_0BAD;
    @(negedge clk);
    check("idle_ready", {31'h0, hrdy[2]}, 32'h1);
    check("idle_resp", {31'h0, hresp[2]}, 32'h0);
    @(posedge clk); #1 htrans = T_BUSY;
    @(negedge clk);
    check("busy_ready", {31'h0, hrdy[2]}, 32'h1);
    check("busy_resp", {31'h0, hresp[2]}, 32'h0);
    @(posedge clk); #1;
    hsel[2] = 1'b0; htrans = T_IDLE; hwdata = 32'h0;
    xfer(2, 32'h20, 1'b0, 3'd2, 32'h0, rd, rsp, nlow);
    check("idle_busy_no_write", rd, 32'hCAFE_F00D);
    check("ws0_read_waits", nlow, 32'd0);

    // Reset during the second wait cycle of a write, three wait states.
    xfer(0, 32'h10, 1'b1, 3'd2, 32'h1111_1111, rd, rsp, nlow);
    check("ws3_write_waits", nlow, 32'd3);
    hsel[0] = 1'b1; haddr = 32'h10; hwrite = 1'b1; hsize = 3'd2; htrans = T_NONSEQ;
    @(posedge clk); #1;
    hsel[0] = 1'b0; htrans = T_IDLE; hwdata = 32'hDEAD_BEEF;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("rst_mid_ready", {31'h0, hrdy[0]}, 32'h1);
    check("rst_mid_resp", {31'h0, hresp[0]}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1 hwdata = 32'h0;
    xfer(0, 32'h10, 1'b0, 3'd2, 32'h0, rd, rsp, nlow);
    check("rst_mid_no_write", rd, 32'h1111_1111);
    check("ws3_read_waits", nlow, 32'd3);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
